rom_word_packer: RTL

ROM_WORD_PACKER -- requirements
Module: rom_word_packer

---
 rtl/rom_word_packer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/rom_word_packer.sv
// rom_word_packer: packs a byte stream into little-endian 16-bit words with
// byte addresses 0, 2, 4, ... A trailing odd byte is emitted zero-padded.
// Optional copier-header stripping is enabled by ROM_PACKER_HEADER_STRIP_EN.
module rom_word_packer #(
   parameter int unsigned HEADER_BYTES = 512,
   parameter int unsigned ADDR_WIDTH   = 25
) (
   input  logic                  clk_74a,
   input  logic                  reset,
   input  logic [31:0]           rom_file_size,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_byte,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [15:0]           data,
   output logic                  wr,
   output logic                  downloading,
   output logic                  header_skipped,
   output logic                  done
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
`ifdef ROM_PACKER_HEADER_STRIP_EN
      S_SKIP   = 3'd1,
`endif
      S_LOW    = 3'd2,
      S_HIGH   = 3'd3,
      S_FLUSH  = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      remain_q, remain_d;
   logic [7:0]            staged_q, staged_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [15:0]           data_q, data_d;
   logic                  wr_q, wr_d;
   logic                  ready_q, ready_d;
   logic                  dl_q, dl_d;
   logic                  done_q, done_d;
   logic                  fire_c;
   logic                  last_c;
`ifdef ROM_PACKER_HEADER_STRIP_EN
   logic [CNT_W-1:0]      hdr_cnt_q, hdr_cnt_d;
   logic                  hs_q, hs_d;
`endif

   assign fire_c = in_valid && ready_q;
   assign last_c = (remain_q == CNT_W'(1));

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d     = state_q;
      remain_d    = remain_q;
      staged_d    = staged_q;
      addr_d      = addr_q;
      next_addr_d = next_addr_q;
      data_d      = data_q;
      wr_d        = 1'b0;
      ready_d     = 1'b0;
      dl_d        = 1'b0;
      done_d      = 1'b0;
`ifdef ROM_PACKER_HEADER_STRIP_EN
      hdr_cnt_d   = hdr_cnt_q;
      hs_d        = hs_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               remain_d    = rom_file_size;
               next_addr_d = '0;
`ifdef ROM_PACKER_HEADER_STRIP_EN
               hs_d        = 1'b0;
`endif
               if (rom_file_size == '0) begin
                  state_d = S_FINISH;
               end
`ifdef ROM_PACKER_HEADER_STRIP_EN
               else if ((HEADER_BYTES != 0) &&
                        ((rom_file_size & 32'h0000_03FF) == 32'(HEADER_BYTES))) begin
                  state_d   = S_SKIP;
                  hdr_cnt_d = CNT_W'(HEADER_BYTES);
                  hs_d      = 1'b1;
               end
`endif
               else begin
                  state_d = S_LOW;
               end
            end
         end
`ifdef ROM_PACKER_HEADER_STRIP_EN
         S_SKIP: begin
            if (fire_c) begin
               remain_d  = remain_q - CNT_W'(1);
               hdr_cnt_d = hdr_cnt_q - CNT_W'(1);
               if (last_c)                          state_d = S_FINISH;
               else if (hdr_cnt_q == CNT_W'(1))     state_d = S_LOW;
            end
         end
`endif
         S_LOW: begin
            if (fire_c) begin
               remain_d = remain_q - CNT_W'(1);
               staged_d = in_byte;
               state_d  = last_c ? S_FLUSH : S_HIGH;
            end
         end
         S_HIGH: begin
            if (fire_c) begin
               remain_d    = remain_q - CNT_W'(1);
               data_d      = {in_byte, staged_q};
               addr_d      = next_addr_q;
               next_addr_d = next_addr_q + ADDR_WIDTH'(2);
               wr_d        = 1'b1;
               state_d     = last_c ? S_FINISH : S_LOW;
            end
         end
         S_FLUSH: begin
            data_d      = {8'h00, staged_q};
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + ADDR_WIDTH'(2);
            wr_d        = 1'b1;
            state_d     = S_FINISH;
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Handshake/status outputs are registered from the upcoming state
      ready_d = (state_d == S_LOW) || (state_d == S_HIGH);
      dl_d    = ready_d || (state_d == S_FLUSH);
      done_d  = (state_d == S_FINISH);
`ifdef ROM_PACKER_HEADER_STRIP_EN
      if (state_d == S_SKIP) begin
         ready_d = 1'b1;
         dl_d    = 1'b1;
      end
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remain_q    <= '0;
         staged_q    <= '0;
         addr_q      <= '0;
         next_addr_q <= '0;
         data_q      <= '0;
         wr_q        <= 1'b0;
         ready_q     <= 1'b0;
         dl_q        <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remain_q    <= remain_d;
         staged_q    <= staged_d;
         addr_q      <= addr_d;
         next_addr_q <= next_addr_d;
         data_q      <= data_d;
         wr_q        <= wr_d;
         ready_q     <= ready_d;
         dl_q        <= dl_d;
         done_q      <= done_d;
      end
   end

`ifdef ROM_PACKER_HEADER_STRIP_EN
   // Header-skip counter and sticky header flag
   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         hdr_cnt_q <= '0;
         hs_q      <= 1'b0;
      end else begin
         hdr_cnt_q <= hdr_cnt_d;
         hs_q      <= hs_d;
      end
   end
   assign header_skipped = hs_q;
`else
   assign header_skipped = 1'b0;
`endif

   assign in_ready    = ready_q;
   assign addr        = addr_q;
   assign data        = data_q;
   assign wr          = wr_q;
   assign downloading = dl_q;
   assign done        = done_q;

endmodule
